// File: rtl/agnmt_burst_sched.sv
// agnmt_burst_sched: two-requester round-robin scheduler for the AGNMT
// N-pulse / MT-period burst generator. Loads one {N, MT} command at a time,
// gates the generator ce, counts end_PW pulses to completion and reports
// done / id / err per command, with a ce-tick watchdog guarding RUN.
// Optional feature: define AGNMT_SCHED_GAP_EN to insert GAP idle ce ticks
// between bursts.
module agnmt_burst_sched #(
    parameter int unsigned       W     = 11,
    parameter int unsigned       TMO_W = 16,
    parameter logic [TMO_W-1:0]  TMO   = 16'd4000,
    parameter int unsigned       GAP   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_n,
    input  logic [W-1:0] req0_mt,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_n,
    input  logic [W-1:0] req1_mt,
    output logic         req1_ready,
    output logic [W-1:0] gen_n,
    output logic [W-1:0] gen_mt,
    output logic         gen_clr,
    output logic         gen_ce,
    input  logic         gen_end_pw,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic         done_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIN  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

`ifdef AGNMT_SCHED_GAP_EN
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`endif

    state_t           state, state_nxt;
    logic [W-1:0]     gen_n_nxt, gen_mt_nxt;
    logic [W-1:0]     pcnt, pcnt_nxt, pcnt_inc;
    logic [TMO_W-1:0] wdog, wdog_nxt, wdog_sat;
    logic             id, id_nxt;
    logic             err, err_nxt;
    logic             last_grant, last_grant_nxt;
    logic             gen_clr_nxt, done_nxt, done_id_nxt, done_err_nxt;
    logic             grant_valid, grant_id;

    // Round-robin arbitration: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        grant_valid = (state == S_IDLE) && (req0_valid || req1_valid);
        grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready  = grant_valid && !grant_id;
        req1_ready  = grant_valid && grant_id;
        gen_ce      = ce && (state == S_RUN);
        busy        = (state != S_IDLE);
        pcnt_inc    = W'(pcnt + W'(1));
        wdog_sat    = (wdog == '1) ? wdog : TMO_W'(wdog + TMO_W'(1));
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt      = state;
        gen_n_nxt      = gen_n;
        gen_mt_nxt     = gen_mt;
        pcnt_nxt       = pcnt;
        wdog_nxt       = wdog;
        id_nxt         = id;
        err_nxt        = err;
        last_grant_nxt = last_grant;
`ifdef AGNMT_SCHED_GAP_EN
        gap_cnt_nxt    = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    gen_n_nxt      = grant_id ? req1_n  : req0_n;
                    gen_mt_nxt     = grant_id ? req1_mt : req0_mt;
                    id_nxt         = grant_id;
                    last_grant_nxt = grant_id;
                    state_nxt      = S_LOAD;
                end
            end
            S_LOAD: begin
                pcnt_nxt = '0;
                wdog_nxt = '0;
                if ((gen_n == '0) || (gen_mt == '0)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_FIN;
                end else begin
                    err_nxt   = 1'b0;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // An end_PW tick never feeds the watchdog, so completion naturally has priority
                if (gen_end_pw) begin
                    pcnt_nxt = pcnt_inc;
                    if (pcnt_inc == gen_n) begin
                        err_nxt   = 1'b0;
                        state_nxt = S_FIN;
                    end
                end else if (ce) begin
                    wdog_nxt = wdog_sat;
                    if (wdog_sat >= TMO) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_FIN;
                    end
                end
            end
            S_FIN: begin
`ifdef AGNMT_SCHED_GAP_EN
                if (GAP > 0) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = S_GAP;
                end else begin
                    state_nxt   = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef AGNMT_SCHED_GAP_EN
            S_GAP: begin
                if (ce) begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        state_nxt = S_IDLE;
                    end else begin
                        gap_cnt_nxt = GAP_W'(gap_cnt + GAP_W'(1));
                    end
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Strobes are registered from the upcoming state so they align with LOAD / FIN
        gen_clr_nxt  = (state_nxt == S_LOAD);
        done_nxt     = (state_nxt == S_FIN);
        done_id_nxt  = (state_nxt == S_FIN) ? id_nxt  : 1'b0;
        done_err_nxt = (state_nxt == S_FIN) ? err_nxt : 1'b0;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gen_n      <= '0;
            gen_mt     <= '0;
            pcnt       <= '0;
            wdog       <= '0;
            id         <= 1'b0;
            err        <= 1'b0;
            last_grant <= 1'b1;
            gen_clr    <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_err   <= 1'b0;
`ifdef AGNMT_SCHED_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            gen_n      <= gen_n_nxt;
            gen_mt     <= gen_mt_nxt;
            pcnt       <= pcnt_nxt;
            wdog       <= wdog_nxt;
            id         <= id_nxt;
            err        <= err_nxt;
            last_grant <= last_grant_nxt;
            gen_clr    <= gen_clr_nxt;
            done       <= done_nxt;
            done_id    <= done_id_nxt;
            done_err   <= done_err_nxt;
`ifdef AGNMT_SCHED_GAP_EN
            gap_cnt    <= gap_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_agnmt_burst_sched.sv
// Directed bench for agnmt_burst_sched (default build, watchdog TMO = 50).
module tb_agnmt_burst_sched;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_n, req0_mt, req1_n, req1_mt;
    logic         req0_ready, req1_ready;
    logic [W-1:0] gen_n, gen_mt;
    logic         gen_clr, gen_ce, gen_end_pw;
    logic         busy, done, done_id, done_err;

    int vectors     = 0;
    int miscompares = 0;

    agnmt_burst_sched #(.W(11), .TMO_W(16), .TMO(16'd50), .GAP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .req0_valid (req0_valid),
        .req0_n     (req0_n),
        .req0_mt    (req0_mt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_n     (req1_n),
        .req1_mt    (req1_mt),
        .req1_ready (req1_ready),
        .gen_n      (gen_n),
        .gen_mt     (gen_mt),
        .gen_clr    (gen_clr),
        .gen_ce     (gen_ce),
        .gen_end_pw (gen_end_pw),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .done_err   (done_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic g;
        logic early_done;

        rst_n = 1'b0; ce = 1'b1; gen_end_pw = 1'b0;
        req0_valid = 1'b0; req0_n = '0; req0_mt = '0;
        req1_valid = 1'b0; req1_n = '0; req1_mt = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_gen_n", 32'(gen_n), 0);
        check("rst_gen_mt", 32'(gen_mt), 0);
        check("rst_gen_clr", 32'(gen_clr), 0);
        check("rst_gen_ce", 32'(gen_ce), 0);

        // Both requesters valid four times: grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_n = 11'd1; req0_mt = 11'd2;
        req1_valid = 1'b1; req1_n = 11'd1; req1_mt = 11'd3;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 1);
            #1;
            check("rr_ready0", 32'(req0_ready), 32'(!g));
            check("rr_ready1", 32'(req1_ready), 32'(g));
            tick();
            check("rr_load_ready0", 32'(req0_ready), 0);
            check("rr_load_ready1", 32'(req1_ready), 0);
            check("rr_gen_mt", 32'(gen_mt), g ? 32'd3 : 32'd2);
            tick();
            gen_end_pw = 1'b1;
            tick();
            gen_end_pw = 1'b0;
            check("rr_done", 32'(done), 1);
            check("rr_done_id", 32'(done_id), 32'(g));
            check("rr_done_err", 32'(done_err), 0);
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();
        end
        #1;
        check("rr_idle_busy", 32'(busy), 0);
        check("rr_idle_ready0", 32'(req0_ready), 0);

        // req0 {N=3, MT=5} alone
        req0_valid = 1'b1; req0_n = 11'd3; req0_mt = 11'd5;
        #1;
        check("t1_ready0", 32'(req0_ready), 1);
        check("t1_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req0_n = 11'd7; req0_mt = 11'd7;
        check("t1_gen_clr", 32'(gen_clr), 1);
        check("t1_load_gen_ce", 32'(gen_ce), 0);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_gen_clr_off", 32'(gen_clr), 0);
        check("t1_run_gen_ce", 32'(gen_ce), 1);
        for (int p = 0; p < 3; p++) begin
            gen_end_pw = 1'b1;
            check("t1_gen_n", 32'(gen_n), 3);
            check("t1_gen_mt", 32'(gen_mt), 5);
            check("t1_no_done", 32'(done), 0);
            tick();
        end
        gen_end_pw = 1'b0;
        check("t1_done", 32'(done), 1);
        check("t1_done_id", 32'(done_id), 0);
        check("t1_done_err", 32'(done_err), 0);
        check("t1_fin_gen_n", 32'(gen_n), 3);
        tick();
        check("t1_done_off", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);

        // req1 {N=0, MT=7}: zero-length, done two cycles after the handshake
        req1_valid = 1'b1; req1_n = 11'd0; req1_mt = 11'd7;
        #1;
        check("z_ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        check("z_gen_clr", 32'(gen_clr), 1);
        check("z_load_done", 32'(done), 0);
        check("z_load_gen_ce", 32'(gen_ce), 0);
        tick();
        check("z_done", 32'(done), 1);
        check("z_done_id", 32'(done_id), 1);
        check("z_done_err", 32'(done_err), 1);
        check("z_fin_gen_ce", 32'(gen_ce), 0);
        tick();
        check("z_idle", 32'(busy), 0);

        // req0 {N=2, MT=5}, no end_PW, ce every other cycle: abort after 50 ce ticks in RUN
        req0_valid = 1'b1; req0_n = 11'd2; req0_mt = 11'd5;
        tick();
        req0_valid = 1'b0;
        tick();
        early_done = 1'b0;
        for (int i = 0; i < 99; i++) begin
            ce = (i % 2 == 0);
            #1;
            if (i < 3) check("wd_gen_ce", 32'(gen_ce), 32'(ce));
            tick();
            if (i < 98) early_done = early_done | done;
        end
        ce = 1'b1;
        check("wd_early_done", 32'(early_done), 0);
        check("wd_done", 32'(done), 1);
        check("wd_done_err", 32'(done_err), 1);
        check("wd_done_id", 32'(done_id), 0);
        check("wd_fin_busy", 32'(busy), 1);
        tick();
        check("wd_busy_drop", 32'(busy), 0);

        // Reset during RUN after one end_PW
        req0_valid = 1'b1; req0_n = 11'd4; req0_mt = 11'd6;
        tick();
        req0_valid = 1'b0;
        tick();
        gen_end_pw = 1'b1;
        tick();
        gen_end_pw = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_gen_n", 32'(gen_n), 0);
        check("mr_gen_mt", 32'(gen_mt), 0);
        check("mr_gen_clr", 32'(gen_clr), 0);
        check("mr_gen_ce", 32'(gen_ce), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_done_id", 32'(done_id), 0);
        check("mr_done_err", 32'(done_err), 0);

        // After reset last_grant is 1 again, so req0 wins the tie
        req0_valid = 1'b1; req0_n = 11'd1; req0_mt = 11'd8;
        req1_valid = 1'b1; req1_n = 11'd1; req1_mt = 11'd9;
        #1;
        check("pr_ready0", 32'(req0_ready), 1);
        check("pr_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("pr_gen_clr", 32'(gen_clr), 1);
        check("pr_gen_n", 32'(gen_n), 1);
        check("pr_gen_mt", 32'(gen_mt), 8);
        tick();
        gen_end_pw = 1'b1;
        tick();
        gen_end_pw = 1'b0;
        check("pr_done", 32'(done), 1);
        check("pr_done_id", 32'(done_id), 0);
        check("pr_done_err", 32'(done_err), 0);
        tick();
        check("pr_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
